ysyx_24080006_axi_rd_arb: RTL and testbench

- Round-robin arbiter that shares the single AXI4 read path (AR/R channels) toward the SoC master port between N core-side read requesters (default: 0 = IFU, 1 = LSU).
- Sits between the core's fetch/load units and the CLINT/JTAG crossbars.
- Allows one outstanding read transaction at a time and supports bursts.
- Checks burst length against the R beats returned and flags protocol errors.

---
 rtl/ysyx_24080006_axi_rd_arb.sv | 119 +++++++++++
 tb/tb_ysyx_24080006_axi_rd_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24080006_axi_rd_arb.sv
// Round-robin arbiter sharing one AXI4 read path (AR/R) among N requesters.
// One outstanding read at a time; burst length is checked against R beats.
module ysyx_24080006_axi_rd_arb #(
  parameter int N_MASTERS = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_MASTERS-1:0]   m_arvalid,
  output logic [N_MASTERS-1:0]   m_arready,
  input  logic [N_MASTERS*49-1:0] m_ar,
  output logic [N_MASTERS-1:0]   m_rvalid,
  input  logic [N_MASTERS-1:0]   m_rready,
  output logic [38:0]            m_r,
  output logic                   s_arvalid,
  input  logic                   s_arready,
  output logic [48:0]            s_ar,
  input  logic                   s_rvalid,
  output logic                   s_rready,
  input  logic [38:0]            s_r,
  output logic [2:0]             grant,
  output logic                   busy,
  output logic                   proto_err
);

  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr_ptr;
  logic [7:0]      beat_cnt;
  logic            ar_hs;
  logic            r_hs;
  logic            cnt_zero;

  // Descending scan so the nearest set bit after ptr wins.
  function automatic logic [IW-1:0] pick(
    input logic [N_MASTERS-1:0] req,
    input logic [IW-1:0]        ptr
  );
    logic [IW-1:0] r;
    int            j;
    r = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      j = int'(ptr) + k;
      if (j >= N_MASTERS) j = j - N_MASTERS;
      if (req[IW'(j)]) r = IW'(j);
    end
    return r;
  endfunction

  assign cnt_zero = (beat_cnt == 8'd0);
  assign ar_hs    = (state == ADDR) && s_arvalid && s_arready;
  assign r_hs     = (state == DATA) && s_rvalid && s_rready;
  assign grant    = 3'(owner);
  assign busy     = (state != IDLE);

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_ar      = m_ar[49*int'(owner) +: 49];
    m_r       = {s_r[38:5], cnt_zero, s_r[3:0]};
    if (state == ADDR) begin
      s_arvalid        = m_arvalid[owner];
      m_arready[owner] = s_arready;
    end
    if (state == DATA) begin
      s_rready        = m_rready[owner];
      m_rvalid[owner] = s_rvalid;
    end
  end

  // The beat counter, not s_r.last, decides where a burst ends.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= IW'(N_MASTERS - 1);
      owner     <= '0;
      beat_cnt  <= 8'd0;
      proto_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|m_arvalid) begin
            owner <= pick(m_arvalid, rr_ptr);
            state <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            beat_cnt <= s_ar[12:5];
            state    <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            if (cnt_zero) begin
              if (!s_r[4]) proto_err <= 1'b1;
              state  <= IDLE;
              rr_ptr <= owner;
            end else begin
              if (s_r[4]) proto_err <= 1'b1;
              beat_cnt <= beat_cnt - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_axi_rd_arb.sv
// Randomized bench for the AXI read arbiter against a transaction-level
// model: round-robin grant order, beat counting and sticky error flag.
module tb_ysyx_24080006_axi_rd_arb;
  localparam int N = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     m_arvalid;
  logic [N-1:0]     m_arready;
  logic [N*49-1:0]  m_ar;
  logic [N-1:0]     m_rvalid;
  logic [N-1:0]     m_rready;
  logic [38:0]      m_r;
  logic             s_arvalid;
  logic             s_arready;
  logic [48:0]      s_ar;
  logic             s_rvalid;
  logic             s_rready;
  logic [38:0]      s_r;
  logic [2:0]       grant;
  logic             busy;
  logic             proto_err;

  int vecs = 0;
  int errs = 0;
  int model_last;
  bit model_perr;

  always #5 clock = ~clock;

  ysyx_24080006_axi_rd_arb #(.N_MASTERS(N)) dut (
    .clock(clock), .reset(reset),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar(m_ar),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_r(m_r),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r),
    .grant(grant), .busy(busy), .proto_err(proto_err)
  );

  function automatic int rr_pick(input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (model_last + k) % N;
      if (req[c]) return c;
    end
    return 0;
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    m_arvalid = '0; m_rready = '0; m_ar = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_r = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_last = N - 1;
    model_perr = 1'b0;
  endtask

  // Starts at #1 after a posedge with the arbiter idle; ends the same way.
  task automatic do_txn(input logic [N-1:0] req, input logic [7:0] len,
                        input bit bp, input int early, input bit nolast,
                        input int rst_at);
    int          w;
    int          b;
    int          cyc;
    bit          hs;
    bit          lastin;
    logic [48:0] pl;
    logic [38:0] beat;
    logic [N-1:0] ev;
    w = rr_pick(req);
    for (int i = 0; i < N; i++)
      m_ar[49*i +: 49] = {32'($urandom), 4'($urandom), len, 3'd2, 2'd1};
    pl = m_ar[49*w +: 49];
    m_arvalid = req; s_arready = 1'b0; s_rvalid = 1'b0; m_rready = '0;
    @(posedge clock); #1;
    vecs++;
    if (busy !== 1'b1 || grant !== 3'(w)) begin
      errs++;
      $display("FAIL arb busy/grant got %b/%0d exp 1/%0d", busy, grant, w);
    end
    vecs++;
    if (s_arvalid !== 1'b1 || s_ar !== pl) begin
      errs++;
      $display("FAIL s_ar got %b/%h exp 1/%h", s_arvalid, s_ar, pl);
    end
    cyc = 0;
    do begin
      s_arready = bp ? 1'($urandom) : 1'b1;
      #1;
      ev = '0; ev[w] = s_arready;
      vecs++;
      if (m_arready !== ev) begin
        errs++;
        $display("FAIL m_arready got %b exp %b", m_arready, ev);
      end
      hs = s_arready;
      @(posedge clock); #1;
      cyc++;
    end while (!hs && cyc < 50);
    if (!hs) begin
      errs++;
      $display("FAIL ar_timeout got 0 exp 1");
      return;
    end
    m_arvalid[w] = 1'b0;
    s_arready = 1'b0;
    b = 0; cyc = 0;
    while (b <= int'(len) && cyc < 400) begin
      vecs++;
      if (proto_err !== model_perr || busy !== 1'b1) begin
        errs++;
        $display("FAIL data_state perr/busy got %b/%b exp %b/1",
                 proto_err, busy, model_perr);
      end
      s_rvalid = bp ? 1'($urandom) : 1'b1;
      m_rready = bp ? N'($urandom) : '1;
      if (nolast) lastin = 1'b0;
      else if (early >= 0 && b == early) lastin = 1'b1;
      else lastin = (b == int'(len));
      beat = {2'($urandom), 32'($urandom), lastin, 4'($urandom)};
      s_r = beat;
      #1;
      ev = '0; ev[w] = s_rvalid;
      vecs++;
      if (s_rready !== m_rready[w] || m_rvalid !== ev) begin
        errs++;
        $display("FAIL r_route rready/rvalid got %b/%b exp %b/%b",
                 s_rready, m_rvalid, m_rready[w], ev);
      end
      hs = s_rvalid && m_rready[w];
      if (hs) begin
        vecs++;
        if (m_r[38:5] !== beat[38:5] || m_r[3:0] !== beat[3:0] ||
            m_r[4] !== (b == int'(len))) begin
          errs++;
          $display("FAIL beat%0d m_r got %h exp %h last %0d",
                   b, m_r, beat, (b == int'(len)));
        end
        if (lastin != (b == int'(len))) model_perr = 1'b1;
      end
      @(posedge clock);
      cyc++;
      if (hs) b++;
      #1;
      if (hs && rst_at >= 0 && b == rst_at) begin
        reset = 1'b1; m_arvalid = '0; m_rready = '1; s_rvalid = 1'b1;
        @(posedge clock); #1;
        vecs++;
        if (busy !== 1'b0 || proto_err !== 1'b0 || s_rready !== 1'b0 ||
            m_rvalid !== '0) begin
          errs++;
          $display("FAIL mid_reset busy/perr/rready/rvalid got %b/%b/%b/%b exp 0/0/0/0",
                   busy, proto_err, s_rready, m_rvalid);
        end
        reset = 1'b0; s_rvalid = 1'b0; m_rready = '0;
        model_last = N - 1; model_perr = 1'b0;
        return;
      end
    end
    s_rvalid = 1'b0; m_rready = '0;
    if (b <= int'(len)) begin
      errs++;
      $display("FAIL r_timeout got %0d beats exp %0d", b, int'(len) + 1);
      return;
    end
    vecs++;
    if (busy !== 1'b0 || proto_err !== model_perr) begin
      errs++;
      $display("FAIL txn_end busy/perr got %b/%b exp 0/%b", busy, proto_err, model_perr);
    end
    model_last = w;
  endtask

  task automatic test_reset;
    do_reset();
    vecs++;
    if (busy !== 1'b0 || grant !== 3'd0 || proto_err !== 1'b0 ||
        m_arready !== '0 || m_rvalid !== '0 || s_arvalid !== 1'b0 ||
        s_rready !== 1'b0) begin
      errs++;
      $display("FAIL reset busy/grant/perr/ar/rv/sav/srr got %b/%0d/%b/%b/%b/%b/%b",
               busy, grant, proto_err, m_arready, m_rvalid, s_arvalid, s_rready);
    end
  endtask

  task automatic test_single;
    do_txn(2'b01, 8'd0, 1'b0, -1, 1'b0, -1);
    do_txn(2'b11, 8'd0, 1'b0, -1, 1'b0, -1);
  endtask

  task automatic test_contention;
    do_reset();
    for (int t = 0; t < 4; t++) do_txn(2'b11, 8'd3, 1'b0, -1, 1'b0, -1);
  endtask

  task automatic test_backpressure;
    for (int t = 0; t < 3; t++) do_txn(2'b11, 8'd7, 1'b1, -1, 1'b0, -1);
  endtask

  task automatic test_early_last;
    do_txn(2'b11, 8'd3, 1'b0, 1, 1'b0, -1);
  endtask

  task automatic test_missing_last;
    do_txn(2'b11, 8'd1, 1'b0, -1, 1'b1, -1);
    do_txn(2'b11, 8'd0, 1'b0, -1, 1'b0, -1);
  endtask

  task automatic test_reset_mid;
    do_txn(2'b11, 8'd3, 1'b0, -1, 1'b0, 1);
    do_txn(2'b11, 8'd0, 1'b0, -1, 1'b0, -1);
  endtask

  task automatic test_random;
    logic [N-1:0] req;
    for (int t = 0; t < 12; t++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      do_txn(req, 8'($urandom_range(0, 5)), 1'b1, -1, 1'b0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
